pcpi_est_frontend: RTL and testbench

PCPI_EST_FRONTEND -- requirements
Module: pcpi_est_frontend

---
 rtl/pcpi_est_frontend_pkg.sv | 29 ++
 rtl/est_ctrl_window.sv | 47 ++++
 rtl/pcpi_est_frontend.sv | 131 +++++++++++++
 tb/tb_pcpi_est_frontend.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_est_frontend_pkg.sv
// Shared definitions for the PCPI estimator front end: FSM state encoding,
// custom-instruction mask/match values and their funct3 codes.
package pcpi_est_frontend_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PUSH     = 3'd1,
      S_CALC     = 3'd2,
      S_WAIT_EST = 3'd3,
      S_RESP     = 3'd4,
      S_DONE     = 3'd5
   } est_state_e;

   localparam logic [6:0]  OPC_CUSTOM = 7'h27;

   localparam logic [2:0]  F3_PUSH = 3'd1;
   localparam logic [2:0]  F3_CALC = 3'd2;
   localparam logic [2:0]  F3_STAT = 3'd3;

   localparam logic [31:0] INSN_MASK  = 32'hfe00707f;
   localparam logic [31:0] MATCH_PUSH = {17'd0, F3_PUSH, 5'd0, OPC_CUSTOM};
   localparam logic [31:0] MATCH_CALC = {17'd0, F3_CALC, 5'd0, OPC_CUSTOM};
   localparam logic [31:0] MATCH_STAT = {17'd0, F3_STAT, 5'd0, OPC_CUSTOM};

   function automatic logic insn_is(input logic [31:0] insn, input logic [31:0] match);
      return (insn & INSN_MASK) == match;
   endfunction

endpackage

// File: rtl/est_ctrl_window.sv
// Control-bit window: a K-deep shift register of N-bit samples (newest in the
// low bits) plus a fill counter that saturates at K.
module est_ctrl_window
   import pcpi_est_frontend_pkg::*;
#(
   parameter int N     = 8,
   parameter int K     = 64,
   parameter int CNT_W = $clog2(K+1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_en,
   input  logic [N-1:0]     push_data,
   output logic [N*K-1:0]   window,
   output logic [CNT_W-1:0] fill_cnt
);

   logic [N*K-1:0]   window_q, window_d;
   logic [CNT_W-1:0] fill_q, fill_d;

   // Shift in a new sample on push; the oldest sample falls off the top.
   always_comb begin
      window_d = window_q;
      fill_d   = fill_q;
      if (push_en) begin
         window_d = {window_q[N*K-N-1:0], push_data};
         if (fill_q != CNT_W'(K)) begin
            fill_d = fill_q + CNT_W'(1);
         end
      end
   end

   // Window and fill registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         window_q <= '0;
         fill_q   <= '0;
      end else begin
         window_q <= window_d;
         fill_q   <= fill_d;
      end
   end

   assign window   = window_q;
   assign fill_cnt = fill_q;

endmodule

// File: rtl/pcpi_est_frontend.sv
// PCPI front end for the estimator: PUSH appends a control sample to the
// window, CALC runs the estimator and returns its result in rd.
// Optional: define EST_FRONTEND_STATUS_EN to enable the STAT instruction,
// which returns the window fill count; otherwise STAT is left unclaimed.
module pcpi_est_frontend
   import pcpi_est_frontend_pkg::*;
#(
   parameter int N     = 8,
   parameter int K     = 64,
   parameter int CNT_W = $clog2(K+1)
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           pcpi_valid,
   input  logic [31:0]    pcpi_insn,
   input  logic [31:0]    pcpi_rs1,
   input  logic [31:0]    pcpi_rs2,
   output logic           pcpi_wr,
   output logic [31:0]    pcpi_rd,
   output logic           pcpi_wait,
   output logic           pcpi_ready,
   output logic [N*K-1:0] ctrl_window,
   output logic           est_start,
   input  logic           est_done,
   input  logic [31:0]    est_result
);

   est_state_e       state_q, state_d;
   logic             wr_q, wr_d;
   logic [31:0]      rd_q, rd_d;
   logic             push_en;
   logic [CNT_W-1:0] fill_cnt;
   logic             is_push, is_calc, is_stat;

   // rs2 and the upper rs1 bits carry nothing for this unit.
   logic unused_inputs;
   assign unused_inputs = ^{pcpi_rs2, pcpi_rs1, fill_cnt};

   assign is_push = insn_is(pcpi_insn, MATCH_PUSH);
   assign is_calc = insn_is(pcpi_insn, MATCH_CALC);
`ifdef EST_FRONTEND_STATUS_EN
   assign is_stat = insn_is(pcpi_insn, MATCH_STAT);
`else
   assign is_stat = 1'b0;
`endif

   est_ctrl_window #(.N(N), .K(K), .CNT_W(CNT_W)) u_window (
      .clk       (clk),
      .resetn    (resetn),
      .push_en   (push_en),
      .push_data (pcpi_rs1[N-1:0]),
      .window    (ctrl_window),
      .fill_cnt  (fill_cnt)
   );

   // Next-state and response latch. The sample is shifted in on the accept
   // edge, so a PUSH aborted later by valid falling still keeps its sample.
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      push_en = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pcpi_valid) begin
               if (is_push) begin
                  push_en = 1'b1;
                  wr_d    = 1'b0;
                  rd_d    = '0;
                  state_d = S_PUSH;
               end else if (is_calc) begin
                  wr_d    = 1'b0;
                  rd_d    = '0;
                  state_d = S_CALC;
               end else if (is_stat) begin
                  wr_d    = 1'b1;
                  rd_d    = 32'(fill_cnt);
                  state_d = S_RESP;
               end
            end
         end
         S_PUSH: begin
            state_d = pcpi_valid ? S_RESP : S_IDLE;
         end
         S_CALC: begin
            state_d = pcpi_valid ? S_WAIT_EST : S_IDLE;
         end
         S_WAIT_EST: begin
            if (!pcpi_valid) begin
               state_d = S_IDLE;
            end else if (est_done) begin
               wr_d    = 1'b1;
               rd_d    = est_result;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            wr_d    = 1'b0;
            rd_d    = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and response registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   assign pcpi_wait  = (state_q == S_PUSH) || (state_q == S_CALC) ||
                       (state_q == S_WAIT_EST) || (state_q == S_RESP);
   assign pcpi_ready = (state_q == S_RESP);
   assign pcpi_wr    = pcpi_ready && wr_q;
   assign pcpi_rd    = pcpi_wr ? rd_q : 32'd0;
   assign est_start  = (state_q == S_CALC);

endmodule

// File: tb/tb_pcpi_est_frontend.sv
module tb_pcpi_est_frontend;

   localparam int N = 8;
   localparam int K = 64;
   localparam int W = N*K;

   localparam logic [31:0] I_PUSH = 32'h0000_1027;
   localparam logic [31:0] I_CALC = 32'h0000_2027;
   localparam logic [31:0] I_STAT = 32'h0000_3027;

   logic          clk;
   logic          resetn;
   logic          pcpi_valid;
   logic [31:0]   pcpi_insn;
   logic [31:0]   pcpi_rs1;
   logic [31:0]   pcpi_rs2;
   logic          pcpi_wr;
   logic [31:0]   pcpi_rd;
   logic          pcpi_wait;
   logic          pcpi_ready;
   logic [W-1:0]  ctrl_window;
   logic          est_start;
   logic          est_done;
   logic [31:0]   est_result;

   int checks = 0;
   int errors = 0;

   pcpi_est_frontend #(.N(N), .K(K)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .pcpi_valid  (pcpi_valid),
      .pcpi_insn   (pcpi_insn),
      .pcpi_rs1    (pcpi_rs1),
      .pcpi_rs2    (pcpi_rs2),
      .pcpi_wr     (pcpi_wr),
      .pcpi_rd     (pcpi_rd),
      .pcpi_wait   (pcpi_wait),
      .pcpi_ready  (pcpi_ready),
      .ctrl_window (ctrl_window),
      .est_start   (est_start),
      .est_done    (est_done),
      .est_result  (est_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction, wait (bounded) for ready, then let DONE pass.
   task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input int max,
                        output int lat, output logic w1, output logic wr, output logic [31:0] rd);
      pcpi_valid = 1'b1;
      pcpi_insn  = insn;
      pcpi_rs1   = rs1;
      lat = -1;
      w1  = 1'b0;
      wr  = 1'b0;
      rd  = '0;
      for (int n = 1; n <= max; n++) begin
         tick();
         if (n == 1) w1 = pcpi_wait;
         if (pcpi_ready) begin
            lat = n;
            wr  = pcpi_wr;
            rd  = pcpi_rd;
            break;
         end
      end
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      tick();
      tick();
   endtask

   initial begin
      int           lat;
      logic         w1, wr, acc;
      logic [31:0]  rd;
      logic [W-1:0] exp_win, snap;
      int           starts;
      logic [7:0]   v;

      resetn     = 1'b0;
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      pcpi_rs1   = '0;
      pcpi_rs2   = 32'hFFFF_FFFF;
      est_done   = 1'b0;
      est_result = '0;
      exp_win    = '0;

      // Reset state
      tick(); tick(); tick();
      chk("rst_wait",   W'(pcpi_wait),  W'(0));
      chk("rst_ready",  W'(pcpi_ready), W'(0));
      chk("rst_wr",     W'(pcpi_wr),    W'(0));
      chk("rst_rd",     W'(pcpi_rd),    W'(0));
      chk("rst_start",  W'(est_start),  W'(0));
      chk("rst_window", ctrl_window,    W'(0));
      resetn = 1'b1;
      tick();

      // Three pushes: A5, 3C, 01
      issue(I_PUSH, 32'hFFFF_FFA5, 10, lat, w1, wr, rd);
      chk("push1_wait", W'(w1),  W'(1));
      chk("push1_lat",  W'(lat), W'(2));
      chk("push1_wr",   W'(wr),  W'(0));
      chk("push1_rd",   W'(rd),  W'(0));
      issue(I_PUSH, 32'h0000_003C, 10, lat, w1, wr, rd);
      chk("push2_lat",  W'(lat), W'(2));
      chk("push2_wr",   W'(wr),  W'(0));
      issue(I_PUSH, 32'h1234_5601, 10, lat, w1, wr, rd);
      chk("push3_lat",  W'(lat), W'(2));
      chk("push3_wr",   W'(wr),  W'(0));
      exp_win = W'(24'hA53C01);
      chk("push3_window", ctrl_window, exp_win);

`ifdef EST_FRONTEND_STATUS_EN
      issue(I_STAT, 32'h0, 10, lat, w1, wr, rd);
      chk("stat3_lat", W'(lat), W'(1));
      chk("stat3_wr",  W'(wr),  W'(1));
      chk("stat3_rd",  W'(rd),  W'(3));
`endif

      // CALC with est_done 5 cycles after est_start (window only partly filled)
      pcpi_valid = 1'b1;
      pcpi_insn  = I_CALC;
      tick();
      chk("calc_start", W'(est_start), W'(1));
      chk("calc_wait",  W'(pcpi_wait), W'(1));
      snap   = ctrl_window;
      starts = 1;
      acc    = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (est_start) starts++;
         acc = acc | pcpi_ready | pcpi_wr;
      end
      est_done   = 1'b1;
      est_result = 32'h0012_3456;
      chk("calc_early_ready", W'(acc), W'(0));
      chk("calc_rd_zero",     W'(pcpi_rd), W'(0));
      chk("calc_window_stable", ctrl_window, snap);
      tick();
      est_done   = 1'b0;
      est_result = 32'hDEAD_BEEF;
      chk("calc_ready", W'(pcpi_ready), W'(1));
      chk("calc_wr",    W'(pcpi_wr),    W'(1));
      chk("calc_rd",    W'(pcpi_rd),    W'(32'h0012_3456));
      chk("calc_starts", W'(starts),    W'(1));
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      tick();
      chk("done_ready", W'(pcpi_ready), W'(0));
      chk("done_rd",    W'(pcpi_rd),    W'(0));
      tick();

      // Stray est_done in IDLE
      est_done = 1'b1;
      tick();
      est_done = 1'b0;
      acc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         acc = acc | pcpi_ready | pcpi_wr | pcpi_wait;
      end
      chk("idle_est_done_ignored", W'(acc), W'(0));

      // Non-matching instruction held valid for 20 cycles
      pcpi_valid = 1'b1;
      pcpi_insn  = 32'h0000_0033;
      acc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         acc = acc | pcpi_wait | pcpi_ready | pcpi_wr;
      end
      chk("nomatch_quiet", W'(acc), W'(0));
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      tick();

`ifndef EST_FRONTEND_STATUS_EN
      // STAT is not claimed when the status feature is absent
      pcpi_valid = 1'b1;
      pcpi_insn  = I_STAT;
      acc = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         acc = acc | pcpi_wait | pcpi_ready | pcpi_wr;
      end
      chk("stat_unclaimed", W'(acc), W'(0));
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      tick();
`endif

      // Abort: valid dropped 2 cycles into WAIT_EST, then a late est_done
      pcpi_valid = 1'b1;
      pcpi_insn  = I_CALC;
      tick();
      tick();
      tick();
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      tick();
      chk("abort_wait", W'(pcpi_wait), W'(0));
      est_done   = 1'b1;
      est_result = 32'h0000_CAFE;
      tick();
      est_done = 1'b0;
      acc = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         acc = acc | pcpi_ready | pcpi_wr | pcpi_wait;
      end
      chk("abort_no_ready", W'(acc), W'(0));
      issue(I_PUSH, 32'h0000_0077, 10, lat, w1, wr, rd);
      chk("abort_push_lat", W'(lat), W'(2));
      chk("abort_push_wr",  W'(wr),  W'(0));
      exp_win = {exp_win[W-N-1:0], 8'h77};
      chk("abort_push_window", ctrl_window, exp_win);

      // K+3 pushes: window holds only the newest K samples
      for (int i = 0; i < K + 3; i++) begin
         v = 8'h80 + 8'(i);
         issue(I_PUSH, {24'h0, v}, 10, lat, w1, wr, rd);
         exp_win = {exp_win[W-N-1:0], v};
      end
      chk("fill_last_lat", W'(lat), W'(2));
      chk("fill_window", ctrl_window, exp_win);
      chk("fill_oldest", W'(ctrl_window[W-1:W-N]), W'(8'h83));
`ifdef EST_FRONTEND_STATUS_EN
      issue(I_STAT, 32'h0, 10, lat, w1, wr, rd);
      chk("statK_lat", W'(lat), W'(1));
      chk("statK_wr",  W'(wr),  W'(1));
      chk("statK_rd",  W'(rd),  W'(K));
`endif

      // Reset in WAIT_EST, est_done during reset and after release
      pcpi_valid = 1'b1;
      pcpi_insn  = I_CALC;
      tick();
      tick();
      resetn = 1'b0;
      tick();
      chk("midrst_wait",   W'(pcpi_wait),  W'(0));
      chk("midrst_window", ctrl_window,      W'(0));
      est_done   = 1'b1;
      est_result = 32'h5555_AAAA;
      tick();
      est_done   = 1'b0;
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      resetn     = 1'b1;
      est_done   = 1'b1;
      tick();
      est_done = 1'b0;
      acc = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         acc = acc | pcpi_ready | pcpi_wr | pcpi_wait;
      end
      chk("midrst_no_ready", W'(acc), W'(0));
      issue(I_PUSH, 32'h0000_005A, 10, lat, w1, wr, rd);
      chk("postrst_push_lat", W'(lat), W'(2));
      chk("postrst_window", ctrl_window, W'(8'h5A));
`ifdef EST_FRONTEND_STATUS_EN
      issue(I_STAT, 32'h0, 10, lat, w1, wr, rd);
      chk("postrst_stat_rd", W'(rd), W'(1));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
